// File: rtl/cfa_scan_ctrl_pkg.sv
// Shared definitions for the CFA raster-scan sequencer: Bayer phase codes,
// CFA layout codes, FSM state encoding and default counter widths.
package cfa_scan_ctrl_pkg;

    localparam int DEF_ROW_W = 11;
    localparam int DEF_COL_W = 11;

    localparam logic [1:0] PH_R  = 2'd0;
    localparam logic [1:0] PH_GR = 2'd1;
    localparam logic [1:0] PH_GB = 2'd2;
    localparam logic [1:0] PH_B  = 2'd3;

    localparam logic [1:0] BAYER_RGGB = 2'd0;
    localparam logic [1:0] BAYER_GRBG = 2'd1;
    localparam logic [1:0] BAYER_GBRG = 2'd2;
    localparam logic [1:0] BAYER_BGGR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_e;

    // Row/column parity flipped by the layout code gives the colour phase.
    function automatic logic [1:0] bayer_phase(input logic row_lsb, input logic col_lsb,
                                               input logic [1:0] order);
        return {row_lsb ^ order[1], col_lsb ^ order[0]};
    endfunction

endpackage

// File: rtl/cfa_scan_ctrl_address_gen.sv
// Combinational linear address generator: addr = row * stride + col.
// DSP selects a plain multiply or an explicit partial-product sum.
module address_gen #(
    parameter int ROW_W = 11,
    parameter int COL_W = 11,
    parameter int DSP   = 0
) (
    input  logic [ROW_W-1:0]       row,
    input  logic [COL_W-1:0]       col,
    input  logic [COL_W-1:0]       stride,
    output logic [ROW_W+COL_W-1:0] addr
);

    localparam int AW = ROW_W + COL_W;

    generate
        if (DSP != 0) begin : g_mul
            assign addr = AW'(row) * AW'(stride) + AW'(col);
        end else begin : g_tree
            logic [AW-1:0] acc;

            // One shifted copy of row per set stride bit; col rides in as the seed term.
            always_comb begin
                acc = AW'(col);
                for (int i = 0; i < COL_W; i++) begin
                    if (stride[i]) begin
                        acc = acc + (AW'(row) << i);
                    end
                end
            end

            assign addr = acc;
        end
    endgenerate

endmodule

// File: rtl/cfa_scan_ctrl.sv
// Raster-scan sequencer for the CFA demosaic datapath: walks one frame
// row-major and presents one registered beat per (row, col) over valid/ready.
module cfa_scan_ctrl
    import cfa_scan_ctrl_pkg::*;
#(
    parameter int         ROW_W       = DEF_ROW_W,
    parameter int         COL_W       = DEF_COL_W,
    parameter int         DSP         = 0,
    parameter logic [1:0] BAYER_ORDER = BAYER_RGGB
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [COL_W-1:0]       col_max,
    input  logic [ROW_W-1:0]       row_max,
    output logic                   busy,
    output logic                   done,
    output logic                   addr_valid,
    input  logic                   addr_ready,
    output logic [ROW_W+COL_W-1:0] addr,
    output logic [ROW_W-1:0]       row_o,
    output logic [COL_W-1:0]       col_o,
    output logic [1:0]             bayer_ph,
    output logic                   first_row,
    output logic                   last_row,
    output logic                   first_col,
    output logic                   last_col,
    output logic [1:0]             fsm_state
);

    localparam int AW = ROW_W + COL_W;

    // Handshake: a beat transfers on any rising edge where addr_valid and
    // addr_ready are both 1. Once raised, addr_valid and the beat fields hold
    // until that transfer; only abort or reset withdraw a beat early.

    scan_state_e      state, state_n;
    logic [COL_W-1:0] cfg_col, cfg_col_n;
    logic [ROW_W-1:0] cfg_row, cfg_row_n;
    logic [ROW_W-1:0] row_q, row_n;
    logic [COL_W-1:0] col_q, col_n;
    logic [AW-1:0]    addr_n;
    logic             load;
    logic             handshake;
    logic             col_end;
    logic             row_end;

    assign handshake = (state == ST_SCAN) && addr_ready;
    assign col_end   = (col_q == cfg_col - COL_W'(1));
    assign row_end   = (row_q == cfg_row - ROW_W'(1));

    always_comb begin
        state_n   = state;
        cfg_col_n = cfg_col;
        cfg_row_n = cfg_row;
        row_n     = row_q;
        col_n     = col_q;
        load      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cfg_col_n = col_max;
                    cfg_row_n = row_max;
                    if ((col_max == '0) || (row_max == '0)) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_SCAN;
                        row_n   = '0;
                        col_n   = '0;
                        load    = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                // Abort wins over a coincident transfer: that beat is consumed, none follows.
                if (abort) begin
                    state_n = ST_IDLE;
                end else if (handshake) begin
                    if (row_end && col_end) begin
                        state_n = ST_DONE;
                    end else begin
                        load = 1'b1;
                        if (col_end) begin
                            col_n = '0;
                            row_n = row_q + ROW_W'(1);
                        end else begin
                            col_n = col_q + COL_W'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Fed with the next-beat coordinates so the address registers alongside them.
    address_gen #(
        .ROW_W (ROW_W),
        .COL_W (COL_W),
        .DSP   (DSP)
    ) u_address_gen (
        .row    (row_n),
        .col    (col_n),
        .stride (cfg_col_n),
        .addr   (addr_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cfg_col   <= '0;
            cfg_row   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            addr      <= '0;
            bayer_ph  <= '0;
            first_row <= 1'b0;
            last_row  <= 1'b0;
            first_col <= 1'b0;
            last_col  <= 1'b0;
        end else begin
            state   <= state_n;
            cfg_col <= cfg_col_n;
            cfg_row <= cfg_row_n;
            if (load) begin
                row_q     <= row_n;
                col_q     <= col_n;
                addr      <= addr_n;
                bayer_ph  <= bayer_phase(row_n[0], col_n[0], BAYER_ORDER);
                first_row <= (row_n == '0);
                last_row  <= (row_n == cfg_row_n - ROW_W'(1));
                first_col <= (col_n == '0);
                last_col  <= (col_n == cfg_col_n - COL_W'(1));
            end
        end
    end

    // A beat is on offer exactly while scanning, so valid and busy share a decode.
    assign addr_valid = (state == ST_SCAN);
    assign busy       = (state == ST_SCAN);
    assign done       = (state == ST_DONE);
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign fsm_state  = state;

endmodule

// File: tb/tb_cfa_scan_ctrl.sv
// Bench for cfa_scan_ctrl: RGGB/compression-tree and BGGR/multiply instances
// share stimulus; a frame model feeds an expected-beat queue drained by a monitor.
module tb_cfa_scan_ctrl;
    import cfa_scan_ctrl_pkg::*;

    localparam int ROW_W = 11;
    localparam int COL_W = 11;
    localparam int AW    = ROW_W + COL_W;
    localparam int W     = ROW_W + COL_W + AW + 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             addr_ready = 1'b0;
    logic [COL_W-1:0] col_max = '0;
    logic [ROW_W-1:0] row_max = '0;

    logic             busy0, done0, valid0, fr0, lr0, fc0, lc0;
    logic [AW-1:0]    addr0;
    logic [ROW_W-1:0] row0;
    logic [COL_W-1:0] col0;
    logic [1:0]       ph0, st0;
    logic             busy3, done3, valid3, fr3, lr3, fc3, lc3;
    logic [AW-1:0]    addr3;
    logic [ROW_W-1:0] row3;
    logic [COL_W-1:0] col3;
    logic [1:0]       ph3, st3;

    cfa_scan_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .DSP(0), .BAYER_ORDER(2'd0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .col_max(col_max), .row_max(row_max), .busy(busy0), .done(done0),
        .addr_valid(valid0), .addr_ready(addr_ready), .addr(addr0),
        .row_o(row0), .col_o(col0), .bayer_ph(ph0),
        .first_row(fr0), .last_row(lr0), .first_col(fc0), .last_col(lc0),
        .fsm_state(st0)
    );

    cfa_scan_ctrl #(.ROW_W(ROW_W), .COL_W(COL_W), .DSP(1), .BAYER_ORDER(2'd3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .col_max(col_max), .row_max(row_max), .busy(busy3), .done(done3),
        .addr_valid(valid3), .addr_ready(addr_ready), .addr(addr3),
        .row_o(row3), .col_o(col3), .bayer_ph(ph3),
        .first_row(fr3), .last_row(lr3), .first_col(fc3), .last_col(lc3),
        .fsm_state(st3)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int last_hs_cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int rdy_mode = 0;   // 0 manual, 1 always ready, 2 pattern 1,0,0,1, 3 random
    int pat_idx = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Colour at (r,c) read from the 2x2 layout tile: r=R, g=G on R row, h=G on B row, b=B.
    function automatic logic [1:0] model_phase(input int order, input int r, input int c);
        string lay;
        byte   ch;
        case (order)
            0:       lay = "rghb";
            1:       lay = "grbh";
            2:       lay = "hbrg";
            default: lay = "bhgr";
        endcase
        ch = lay[(r % 2) * 2 + (c % 2)];
        if (ch == "r") return PH_R;
        if (ch == "g") return PH_GR;
        if (ch == "h") return PH_GB;
        return PH_B;
    endfunction

    function automatic logic [W-1:0] pack_beat(input int r, input int c, input int stride, input int rows);
        return {ROW_W'(r), COL_W'(c), AW'(r * stride + c),
                r == 0, r == rows - 1, c == 0, c == stride - 1};
    endfunction

    function automatic logic [W-1:0] beat_of0();
        return {row0, col0, addr0, fr0, lr0, fc0, lc0};
    endfunction

    function automatic logic [W-1:0] beat_of3();
        return {row3, col3, addr3, fr3, lr3, fc3, lc3};
    endfunction

    function automatic logic [63:0] all_out0();
        return 64'({valid0, busy0, done0, addr0, row0, col0, ph0, fr0, lr0, fc0, lc0});
    endfunction

    function automatic logic [63:0] all_out3();
        return 64'({valid3, busy3, done3, addr3, row3, col3, ph3, fr3, lr3, fc3, lc3});
    endfunction

    task automatic push_frame(input int c, input int r);
        for (int rr = 0; rr < r; rr++) begin
            for (int cc = 0; cc < c; cc++) begin
                exp_q.push_back(pack_beat(rr, cc, c, r));
            end
        end
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic         stalled;
        logic [W-1:0] held0, held3, e;
        int           er, ec;
        stalled = 1'b0;
        held0 = '0;
        held3 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                check("valid_match", 64'(valid3), 64'(valid0));
                if (stalled && valid0) begin
                    check("stall_hold0", 64'(beat_of0()), 64'(held0));
                    check("stall_hold3", 64'(beat_of3()), 64'(held3));
                end
                stalled = 1'b0;
                if (valid0) begin
                    check("busy_with_beat", 64'(busy0), 64'd1);
                    if (addr_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat actual addr=%0d required=no beat", addr0);
                        end else begin
                            e  = exp_q.pop_front();
                            er = int'(e[W-1 -: ROW_W]);
                            ec = int'(e[W-1-ROW_W -: COL_W]);
                            check("beat0", 64'(beat_of0()), 64'(e));
                            check("beat3", 64'(beat_of3()), 64'(e));
                            check("phase0", 64'(ph0), 64'(model_phase(0, er, ec)));
                            check("phase3", 64'(ph3), 64'(model_phase(3, er, ec)));
                        end
                        hs_count++;
                        last_hs_cyc = cyc;
                    end else if (!abort) begin
                        stalled = 1'b1;
                        held0 = beat_of0();
                        held3 = beat_of3();
                    end
                end
                if (done0 || done3) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check("done_match", 64'(done3), 64'(done0));
                    check("busy_valid_at_done", 64'({busy0, valid0}), 64'd0);
                end
            end
        end
    end

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: addr_ready = 1'b1;
                2: begin
                    addr_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
                    pat_idx++;
                end
                3: addr_ready = ($urandom_range(0, 2) != 0);
                default: ;
            endcase
        end
    end

    // ---------------- driver tasks (entered and left at posedge+#1) ----------------
    task automatic set_mode(input int m);
        rdy_mode = m;
        pat_idx  = 0;
        if (m == 1) addr_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int c, input int r, output int s, output int base);
        col_max  = COL_W'(c);
        row_max  = ROW_W'(r);
        start    = 1'b1;
        hs_count = 0;
        base     = done_cnt;
        push_frame(c, r);
        @(posedge clk);
        #1;
        start = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input int s, input int n, input bit timed, input int base);
        int k;
        k = 0;
        while (done_cnt == base && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done_cnt == base) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=no done required=done within 400 cycles");
        end else begin
            if (timed) check("done_cycle", 64'(done_cyc - s), 64'(n + 1));
            else check("done_after_last_hs", 64'(done_cyc - last_hs_cyc), 64'd1);
        end
        check("hs_count", 64'(hs_count), 64'(n));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("done_once", 64'(done_cnt - base), 64'd1);
        check("idle_after_done", 64'({busy0, valid0, busy3, valid3}), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int s, base, k, c, r, m;

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs0", all_out0(), 64'd0);
        check("reset_outputs3", all_out3(), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_outputs0", all_out0(), 64'd0);

        // 4x3 frame, always ready
        set_mode(1);
        start_frame(4, 3, s, base);
        check("first_beat_latency", 64'({valid0, busy0, addr0}), 64'({1'b1, 1'b1, 22'd0}));
        wait_done(s, 12, 1'b1, base);

        // same frame with ready 1,0,0,1
        set_mode(2);
        start_frame(4, 3, s, base);
        wait_done(s, 12, 1'b0, base);

        // empty frame; start held into the DONE cycle must be ignored
        set_mode(1);
        start_frame(0, 5, s, base);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(s, 0, 1'b1, base);

        // single-pixel frame
        start_frame(1, 1, s, base);
        check("single_flags", 64'({fr0, lr0, fc0, lc0, fr3, lr3, fc3, lc3}), 64'hFF);
        wait_done(s, 1, 1'b1, base);

        // 5x2 frame; col_max change and a start while busy both ignored
        set_mode(2);
        start_frame(5, 2, s, base);
        repeat (3) @(posedge clk);
        #1;
        col_max = 7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(s, 10, 1'b0, base);

        // reset after the 3rd handshake
        set_mode(1);
        start_frame(4, 3, s, base);
        k = 0;
        while (hs_count < 3 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reached_3_hs", 64'(hs_count), 64'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midscan_reset0", all_out0(), 64'd0);
        check("midscan_reset3", all_out3(), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        check("no_done_on_reset", 64'(done_cnt - base), 64'd0);
        start_frame(4, 3, s, base);
        wait_done(s, 12, 1'b1, base);

        // abort while stalled on addr 2, restart on the following cycle
        set_mode(0);
        addr_ready = 1'b1;
        start_frame(4, 3, s, base);
        k = 0;
        while (hs_count < 2 && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
        addr_ready = 1'b0;
        abort = 1'b1;
        check("abort_at_addr2", 64'({valid0, addr0}), 64'({1'b1, 22'd2}));
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_outputs", 64'({valid0, busy0, done0, valid3, busy3, done3}), 64'd0);
        check("no_done_on_abort", 64'(done_cnt - base), 64'd0);
        exp_q.delete();
        addr_ready = 1'b1;
        start_frame(3, 2, s, base);
        check("restart_accepted", 64'({valid0, addr0}), 64'({1'b1, 22'd0}));
        wait_done(s, 6, 1'b1, base);

        // randomized frames and ready behaviour
        for (int i = 0; i < 25; i++) begin
            c = $urandom_range(0, 6);
            r = $urandom_range(0, 5);
            m = $urandom_range(1, 3);
            set_mode(m);
            start_frame(c, r, s, base);
            wait_done(s, c * r, (m == 1) || (c * r == 0), base);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfa_scan_ctrl.md
Name: cfa_scan_ctrl

Overview:
- Raster-scan sequencer for the CFA demosaicing datapath. Once `start` is issued, it walks (row, col) across one frame, row-major from (0,0) to (row_max-1, col_max-1).
- Each beat carries a linear pixel address (row*col_max+col), the Bayer colour phase and window border flags.
- Drives the frame-buffer read port through a valid/ready handshake.
- Address arithmetic is delegated to the existing address_gen block.

Parameters:
- ROW_W, 11, row counter / row_max width
- COL_W, 11, col counter / col_max width (line stride)
- DSP, 0, forwarded to address_gen (1 = behavioural multiply, 0 = compression-tree MAC)
- BAYER_ORDER, 0, 2-bit CFA layout: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  begin frame; sampled only in IDLE
- abort  in  1  terminate scan; sampled only in SCAN
- col_max  in  COL_W  columns per row (stride); latched at start
- row_max  in  ROW_W  rows per frame; latched at start
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse, frame completed
- addr_valid  out  1  beat valid
- addr_ready  in  1  consumer accepts beat
- addr  out  ROW_W+COL_W  row*col_max+col
- row_o  out  ROW_W  beat row
- col_o  out  COL_W  beat column
- bayer_ph  out  2  0 R, 1 Gr, 2 Gb, 3 B
- first_row, last_row, first_col, last_col  out  1 each  border flags for the beat

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clock edge): state IDLE. busy, done and addr_valid are 0. addr, row_o, col_o and bayer_ph are 0. All border flags are 0. Applies mid-scan with no done pulse.
- FSM has three states: IDLE, SCAN, DONE.
- IDLE + start at edge t:
  - Latch cfg_col/cfg_row.
  - If either is 0, go to DONE: no beats are issued.
  - Otherwise go to SCAN and load beat (0,0). The next-cycle values are addr=0, addr_valid=1, busy=1. First beat latency is 1 cycle.
- SCAN:
  - A handshake is addr_valid & addr_ready at an edge.
  - On a handshake that is not the final beat: advance col. At col=cfg_col-1, col wraps to 0 and row increments.
  - Outputs are registered. The next beat's addr comes from address_gen fed with the next (row,col) and cfg_col, and is registered on the same edge.
  - On the final-beat handshake (row=cfg_row-1, col=cfg_col-1): addr_valid goes to 0 and the state goes to DONE.
  - Without a handshake, all beat outputs hold stable; addr_valid never drops except on abort/reset.
- abort in SCAN: the next cycle has addr_valid=0, busy=0 and the state is IDLE, with no done. A handshake in the same cycle as abort still counts as consumed, but no further beat follows.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- start while busy is ignored. col_max/row_max changes after latching have no effect until the next start.
- bayer_ph = {row_o[0]^BAYER_ORDER[1], col_o[0]^BAYER_ORDER[0]}. It is registered with the beat.
- Border flags:
  - first_row = (row_o==0)
  - last_row = (row_o==cfg_row-1)
  - first_col = (col_o==0)
  - last_col = (col_o==cfg_col-1)
  - All are registered with the beat.
- addr width is ROW_W+COL_W. The maximum product cannot overflow. Counter compares use the latched values, with no modulo wrap beyond cfg limits.
- Throughput: 1 beat/cycle when addr_ready is held high.

Decomposition:
- Shared package holds:
  - CFA phase encodings (PH_R, PH_GR, PH_GB, PH_B)
  - BAYER_ORDER codes
  - FSM state encoding
  - default ROW_W/COL_W
- One sub-module: existing address_gen, instantiated once, combinational, fed with next-beat coordinates. Counters, FSM and flags stay in cfa_scan_ctrl.

Test Plan:
- col_max=4, row_max=3, ready=1, BAYER_ORDER=0, start at t:
  - 12 beats on t+1..t+12 with addr 0..11.
  - bayer_ph sequence row0 = 0,1,0,1 and row1 = 2,3,2,3.
  - last_col on addr 3,7,11.
  - done at t+13, busy low from t+13.
- Same frame with addr_ready toggling 1,0,0,1 (repeating):
  - Outputs held stable across stalls.
  - Addresses are 0..11 with no duplicates or skips.
  - done exactly once, the cycle after the 12th handshake.
- col_max=0 (row_max=5), then col_max=1/row_max=1:
  - First case: no addr_valid, done at t+1.
  - Second case: single beat addr=0 with all four border flags set, done at t+2.
- col_max=5, row_max=2, BAYER_ORDER=3; change col_max to 7 mid-scan:
  - addr 0..9 using stride 5.
  - (0,0) gives bayer_ph=3 and (1,1) gives bayer_ph=0.
- rst_n=0 for one edge after the 3rd handshake:
  - Next cycle addr_valid=0, busy=0, all outputs 0, no done.
  - A fresh start restarts at addr 0.
- abort asserted with addr_valid=1, addr_ready=0 at addr=2:
  - Next cycle addr_valid=0 and busy=0, with no done.
  - A start on the following cycle is accepted.
